// File: rtl/risc_v_mem_pkg.sv
// Shared constants for the instruction/data RAM and the types of its boot-time loader.
// The RAM read port and ram_loader both take their geometry from here.
package risc_v_mem_pkg;

  localparam int ADDR_W         = 9;
  localparam int DATA_W         = 32;
  localparam int LEN_W          = 10;
  localparam int BYTES_PER_WORD = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE
  } loader_state_e;

endpackage

// File: rtl/ram_loader_byte_packer.sv
// Packs a stream of bytes little-endian into RAM words.
// word_valid_o is raised in the same cycle that the final byte of a word is taken.
module byte_packer #(
  parameter int DATA_W = risc_v_mem_pkg::DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              take_i,
  input  logic [7:0]        byte_i,
  output logic [DATA_W-1:0] word_o,
  output logic              word_valid_o
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] shift_q;

  // Each byte enters at the top, so once a word is complete byte 0 sits in bits [7:0].
  assign word_o       = {byte_i, shift_q[DATA_W-1:8]};
  assign word_valid_o = take_i && (idx_q == LAST_IDX);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the values from before the edge no matter how the blocks are ordered.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      idx_q   <= '0;
      shift_q <= '0;
    end else if (take_i) begin
      shift_q <= word_o;
      idx_q   <= word_valid_o ? '0 : idx_q + IDX_W'(1);
    end
  end

endmodule

// File: rtl/ram_loader.sv
// Fills the instruction/data RAM from a byte stream before the core leaves reset.
// It writes len words to consecutive addresses from 0, then pulses done_o.
module ram_loader #(
  parameter int ADDR_W = risc_v_mem_pkg::ADDR_W,
  parameter int DATA_W = risc_v_mem_pkg::DATA_W,
  parameter int LEN_W  = risc_v_mem_pkg::LEN_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              WE_o,
  output logic [ADDR_W-1:0] A_o,
  output logic [DATA_W-1:0] WD_o,
  output logic              busy_o,
  output logic              done_o
);

  import risc_v_mem_pkg::*;

  localparam int unsigned MAX_WORDS = 2 ** ADDR_W;

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] last_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  logic              take;
  logic              load_start;
  logic [DATA_W-1:0] word;
  logic              word_valid;
  logic [LEN_W-1:0]  len_clamped;
  logic [LEN_W-1:0]  last_full;

  byte_packer #(
    .DATA_W (DATA_W)
  ) u_packer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (load_start),
    .take_i       (take),
    .byte_i       (byte_i),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  // The stored value is the index of the final word, so a full 2**ADDR_W load
  // still fits the address width and the address can never wrap.
  assign len_clamped = (len_i > LEN_W'(MAX_WORDS)) ? LEN_W'(MAX_WORDS) : len_i;
  assign last_full   = len_clamped - LEN_W'(1);

  assign byte_ready_o = (state_q == COLLECT);
  assign take         = byte_ready_o && byte_valid_i;
  assign load_start   = (state_q == IDLE) && start_i;
  assign WE_o         = (state_q == WRITE);
  assign busy_o       = (state_q == COLLECT) || (state_q == WRITE);
  assign done_o       = (state_q == DONE);
  assign A_o          = addr_q;
  assign WD_o         = data_q;

  // NOTE: the state is only a handful of flops, so all of it is reset,
  // including the address/data holding registers that drive the RAM port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_start) begin
        idx_q  <= '0;
        last_q <= last_full[ADDR_W-1:0];
      end
      if (word_valid) begin
        addr_q <= idx_q;
        data_q <= word;
      end
      if ((state_q == WRITE) && (idx_q != last_q)) begin
        idx_q <= idx_q + ADDR_W'(1);
      end
    end
  end

  // NOTE: next state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = (len_i == '0) ? DONE : COLLECT;
      COLLECT: if (word_valid) state_d = WRITE;
      WRITE:   state_d = (idx_q == last_q) ? DONE : COLLECT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: expected RAM writes are queued as stimulus is issued
// and a negedge monitor pops and compares them whenever WE_o is high.
module tb_ram_loader;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 10;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              start_i = 1'b0;
  logic [LEN_W-1:0]  len_i = '0;
  logic [7:0]        byte_i = '0;
  logic              byte_valid_i = 1'b0;
  logic              byte_ready_o;
  logic              WE_o;
  logic [ADDR_W-1:0] A_o;
  logic [DATA_W-1:0] WD_o;
  logic              busy_o;
  logic              done_o;

  wr_t               exp_q[$];
  wr_t               mon_exp;
  logic [DATA_W-1:0] ram [0:(2**ADDR_W)-1];
  logic [ADDR_W-1:0] last_addr = '0;
  int                n_checks = 0;
  int                n_errors = 0;
  int                wr_count = 0;
  int                done_count = 0;

  ram_loader dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .len_i        (len_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .WE_o         (WE_o),
    .A_o          (A_o),
    .WD_o         (WD_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done_o) done_count++;
    if (WE_o) begin
      wr_count++;
      last_addr = A_o;
      ram[A_o]  = WD_o;
      check("ready_low_during_we", {31'b0, byte_ready_o}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'd1, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("we_addr", {23'b0, A_o}, {23'b0, mon_exp.addr});
        check("we_data", WD_o, mon_exp.data);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int len);
    start_i = 1'b1;
    len_i   = LEN_W'(len);
    tick();
    start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited = 0;
    byte_i       = b;
    byte_valid_i = 1'b1;
    while (!byte_ready_o && waited < 50) begin
      tick();
      waited++;
    end
    if (!byte_ready_o) check("byte_accept_timeout", 32'd0, 32'd1);
    tick();
    byte_valid_i = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_word(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                           input int gap);
    wr_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
    for (int k = 0; k < 4; k++) send_byte(data[8*k +: 8], gap);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!done_o && n < budget) begin
      tick();
      n++;
    end
    check(name, {31'b0, done_o}, 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_we"},    {31'b0, WE_o},         32'd0);
    check({tag, "_addr"},  {23'b0, A_o},          32'd0);
    check({tag, "_wd"},    WD_o,                  32'd0);
    check({tag, "_busy"},  {31'b0, busy_o},       32'd0);
    check({tag, "_done"},  {31'b0, done_o},       32'd0);
    check({tag, "_ready"}, {31'b0, byte_ready_o}, 32'd0);
  endtask

  function automatic logic [7:0] stream_byte(input int i);
    return 8'((i * 5) + 1);
  endfunction

  localparam logic [31:0] T2_WORDS [0:2] = '{32'h03020100, 32'h07060504, 32'h0B0A0908};

  initial begin
    int wc;
    int ready_seen;
    logic [DATA_W-1:0] w;

    // Reset state
    tick();
    tick();
    check_idle_outputs("reset");
    rst_i = 1'b0;
    tick();

    // Single word, back-to-back bytes, latency and read-back
    start(1);
    check("t1_busy", {31'b0, busy_o}, 32'd1);
    check("t1_ready", {31'b0, byte_ready_o}, 32'd1);
    send_word(9'd0, 32'h12345678, 0);
    check("t1_we_next_cycle", {31'b0, WE_o}, 32'd1);
    tick();
    check("t1_done", {31'b0, done_o}, 32'd1);
    check("t1_busy_at_done", {31'b0, busy_o}, 32'd0);
    tick();
    check("t1_done_one_cycle", {31'b0, done_o}, 32'd0);
    check("t1_ram_read", ram[0], 32'h12345678);

    // Three words with a bubble after every byte
    start(3);
    for (int i = 0; i < 3; i++) send_word(ADDR_W'(i), T2_WORDS[i], 1);
    wait_done("t2_done", 10);
    tick();
    check("t2_queue_empty", exp_q.size(), 32'd0);

    // Zero-length load
    wc = wr_count;
    start(0);
    check("t3_done", {31'b0, done_o}, 32'd1);
    check("t3_busy", {31'b0, busy_o}, 32'd0);
    tick();
    check("t3_done_cleared", {31'b0, done_o}, 32'd0);
    check("t3_busy_after", {31'b0, busy_o}, 32'd0);
    check("t3_no_writes", wr_count - wc, 32'd0);

    // Oversized length clamps to the full RAM
    wc = wr_count;
    start(600);
    for (int wi = 0; wi < 512; wi++) begin
      for (int k = 0; k < 4; k++) w[8*k +: 8] = stream_byte(4 * wi + k);
      send_word(ADDR_W'(wi), w, 0);
    end
    wait_done("t4_done", 3);
    check("t4_write_count", wr_count - wc, 32'd512);
    check("t4_last_addr", {23'b0, last_addr}, 32'd511);
    ready_seen = 0;
    byte_i       = 8'hEE;
    byte_valid_i = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (byte_ready_o) ready_seen++;
      tick();
    end
    byte_valid_i = 1'b0;
    check("t4_extra_bytes_refused", ready_seen, 32'd0);
    check("t4_no_extra_writes", wr_count - wc, 32'd512);

    // Reset in the middle of word 5
    wc = wr_count;
    start(8);
    for (int wi = 0; wi < 5; wi++) send_word(ADDR_W'(wi), 32'hA0A0A0A0 + 32'(wi), 0);
    send_byte(8'hE1, 0);
    send_byte(8'hE2, 0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_idle_outputs("t5_after_reset");
    byte_i       = 8'h99;
    byte_valid_i = 1'b1;
    repeat (6) tick();
    byte_valid_i = 1'b0;
    check("t5_no_write_after_reset", wr_count - wc, 32'd5);
    start(1);
    send_word(9'd0, 32'hDDCCBBAA, 0);
    wait_done("t5_restart_done", 3);
    tick();

    // start_i while busy is ignored
    wc = wr_count;
    start(2);
    exp_q.push_back(wr_t'{addr: 9'd0, data: 32'h44332211});
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    start(5);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    start(7);
    send_word(9'd1, 32'h88776655, 0);
    wait_done("t6_done", 3);
    repeat (10) tick();
    check("t6_write_count", wr_count - wc, 32'd2);
    check("t6_busy_after", {31'b0, busy_o}, 32'd0);

    check("final_queue_empty", exp_q.size(), 32'd0);
    check("final_done_pulses", done_count, 32'd6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Write-side counterpart to the instruction/data RAM read port (9-bit word address, 32-bit data).
- Accepts a byte stream with a valid/ready handshake, e.g. from a serial receiver.
- Packs every 4 bytes little-endian into a 32-bit word and issues one-cycle write strobes to consecutive RAM addresses from 0.
- Runs before the core leaves reset, to fill program memory.

Parameters:
ADDR_W, 9, RAM word-address width (depth 2**ADDR_W = 512 words)
DATA_W, 32, RAM word width; must be a multiple of 8
LEN_W, 10, width of the word-count input (holds 0..2**ADDR_W)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  one-cycle request to begin a load; sampled only in IDLE
len_i  in  LEN_W  number of words to load; sampled with start_i
byte_i  in  8  incoming byte
byte_valid_i  in  1  byte_i valid
byte_ready_o  out  1  loader accepts byte this cycle
WE_o  out  1  RAM write enable, one cycle per word
A_o  out  ADDR_W  RAM write word address
WD_o  out  DATA_W  RAM write data
busy_o  out  1  load in progress
done_o  out  1  one-cycle pulse when load completes

Behaviour:
- Reset (synchronous, rst_i high at posedge): state IDLE; WE_o=0, A_o=0, WD_o=0, busy_o=0, done_o=0, byte_ready_o=0; byte counter and word counter cleared; partial word discarded.
- Reset mid-load aborts immediately. No further WE_o pulses. No done_o.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE:
  - start_i=1 with len_i=0 -> DONE (no writes).
  - start_i=1 with len_i>0 -> latch len = min(len_i, 2**ADDR_W); word index=0; byte index=0; go to COLLECT.
- COLLECT:
  - byte_ready_o=1, busy_o=1.
  - A byte transfers when byte_valid_i&&byte_ready_o at posedge.
  - Byte k of the word (k=0..3) goes to WD bits [8k+7:8k].
  - After the 4th byte -> WRITE.
  - byte_valid_i low stalls indefinitely; no timeout.
- WRITE (exactly 1 cycle):
  - WE_o=1, A_o=word index, WD_o=assembled word; byte_ready_o=0.
  - If word index==len-1 -> DONE; else word index+1 and -> COLLECT.
- DONE (1 cycle): done_o=1, busy_o=0 -> IDLE.
- WE_o is 0 in every state except WRITE. A_o and WD_o hold their last values outside WRITE.
- Throughput: 5 cycles per word minimum (4 byte beats + 1 write cycle).
- Latency: last byte accepted at posedge N -> WE_o high in cycle N+1 -> done_o in cycle N+2.
- start_i is ignored while busy_o=1 or in DONE.
- Bytes are never accepted outside COLLECT.
- len_i > 2**ADDR_W is clamped to 2**ADDR_W. The address never wraps; the last write goes to 2**ADDR_W-1.

Decomposition:
- Shared package risc_v_mem_pkg holds:
  - ADDR_W and DATA_W constants, shared with the RAM.
  - BYTES_PER_WORD = DATA_W/8.
  - The loader state enum typedef (IDLE, COLLECT, WRITE, DONE).
- One natural sub-module: byte_packer. It holds the byte index and the shift/insert register, with outputs word_o and word_valid_o.
- The top-level FSM owns the address counter, length compare and done pulse.

Test Plan:
- Reset then start_i with len_i=1; bytes 0x78,0x56,0x34,0x12 back-to-back -> one WE_o pulse with A_o=0, WD_o=0x12345678; done_o exactly 1 cycle later; a RAM read at address 0 returns 0x12345678.
- len_i=3 with byte_valid_i toggled every other cycle, bytes 0x00..0x0B -> WE_o at addresses 0,1,2 with 0x03020100, 0x07060504, 0x0B0A0908; byte_ready_o=0 during each WE_o cycle.
- len_i=0 -> no WE_o; done_o pulses the cycle after start_i; busy_o stays 0.
- len_i=600 streaming 2400 bytes -> exactly 512 writes, last at A_o=511; done_o after write 511; byte_ready_o stays 0 afterwards (extra bytes not accepted).
- rst_i asserted after 2 of 4 bytes in word 5 -> no WE_o follows; all outputs 0 next cycle. A new start with len_i=1 writes A_o=0 from fresh bytes (no stale partial data).
- start_i pulsed again while busy_o=1 -> ignored; the original word count and addresses complete unchanged.
